// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed RAM behind a req/ready handshake with a
// programmable number of wait states per transaction.
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        WE,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  output logic [31:0] data_from_mem,
  output logic        ready,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg;
  logic            we_reg;
  logic [31:0]     addr_reg;
  logic [31:0]     data_reg;
  logic [31:0]     ram [DEPTH];

  logic            accept;
  logic            enter_respond;
  logic [31:0]     eff_addr;
  logic            eff_we;
  logic [AW-1:0]   eff_idx;
  logic [AW-1:0]   lat_idx;
  logic            lat_invalid;
  logic            eff_invalid;

  function automatic logic invalid_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
  endfunction

  // With zero wait states RESPOND is entered on the accepting edge, so the
  // load lookup must use the live inputs rather than the latched copies.
  assign eff_addr    = (state_reg == IDLE) ? address_to_mem : addr_reg;
  assign eff_we      = (state_reg == IDLE) ? WE : we_reg;
  assign eff_idx     = eff_addr[AW+1:2];
  assign eff_invalid = invalid_addr(eff_addr);
  assign lat_idx     = addr_reg[AW+1:2];
  assign lat_invalid = invalid_addr(addr_reg);
  assign accept      = (state_reg == IDLE) && req;

  always_comb begin
    state_next    = state_reg;
    enter_respond = 1'b0;
    ready         = 1'b0;
    err           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_next = WAIT;
          end else begin
            state_next    = RESPOND;
            enter_respond = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next    = RESPOND;
          enter_respond = 1'b1;
        end
      end
      RESPOND: begin
        ready      = 1'b1;
        err        = lat_invalid;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      we_reg        <= 1'b0;
      addr_reg      <= 32'd0;
      data_reg      <= 32'd0;
      data_from_mem <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg   <= WE;
        addr_reg <= address_to_mem;
        data_reg <= data_to_mem;
        cnt_reg  <= CNT_INIT;
      end else if (state_reg == WAIT) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      if (enter_respond && !eff_we) begin
        data_from_mem <= eff_invalid ? 32'd0 : ram[eff_idx];
      end
    end
  end

  // Store commits as RESPOND ends; an async reset drops state to IDLE first.
  always_ff @(posedge clk) begin
    if (state_reg == RESPOND && we_reg && !lat_invalid) begin
      ram[lat_idx] <= data_reg;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one instance with 2 wait states, one with 0 wait states.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] dout;
  logic        rdy, err;
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic [31:0] dout0;
  logic        rdy0, err0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(64), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .WE(we), .address_to_mem(addr),
    .data_to_mem(wdata), .data_from_mem(dout), .ready(rdy), .err(err)
  );

  data_mem_responder #(.DEPTH(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .WE(we0), .address_to_mem(addr0),
    .data_to_mem(wdata0), .data_from_mem(dout0), .ready(rdy0), .err(err0)
  );

  // Issues one transaction on the 2-wait-state instance; lat counts falling
  // edges from the accepting edge until ready (-1 if it never came).
  task automatic run_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input bit toggle, output logic [31:0] rd, output bit e,
                         output int lat);
    bit seen = 0;
    lat = 0;
    rd = 32'hX;
    e = 1'b0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (rdy) begin
        seen = 1;
        rd = dout;
        e = err;
      end else if (toggle) begin
        we = ~w; addr = 32'h10; wdata = 32'h1234_5678;
      end
    end
    req = 1'b0;
    if (!seen) lat = -1;
    $display("txn we=%0b addr=%h data=%h -> rdata=%h err=%0b lat=%0d", w, a, d, rd, e, lat);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", rdy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (dout !== 32'd0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout); end
    checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL reset_ready0 got=%b exp=0", rdy0); end
    checks++; if (dout0 !== 32'd0) begin failures++; $display("FAIL reset_dout0 got=%h exp=0", dout0); end
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; bit e; int lat;
    run_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, rd, e, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL store_latency got=%0d exp=3", lat); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL store_err got=%b exp=0", e); end
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL store_dout_held got=%h exp=0", rd); end
    run_txn(1'b0, 32'h10, 32'd0, 1'b0, rd, e, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL load_latency got=%0d exp=3", lat); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL load_err got=%b exp=0", e); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_data got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0; wdata0 = 32'h1;
    @(negedge clk);
    $display("b2b store ready0=%b err0=%b", rdy0, err0);
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL b2b_store_ready got=%b exp=1", rdy0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL b2b_store_err got=%b exp=0", err0); end
    we0 = 1'b0;
    @(negedge clk);
    checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL b2b_gap_ready got=%b exp=0", rdy0); end
    @(negedge clk);
    $display("b2b load ready0=%b err0=%b rdata=%h", rdy0, err0, dout0);
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL b2b_load_ready got=%b exp=1", rdy0); end
    checks++; if (dout0 !== 32'h1) begin failures++; $display("FAIL b2b_load_data got=%h exp=00000001", dout0); end
    req0 = 1'b0;
    @(negedge clk);
    checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL b2b_idle_ready got=%b exp=0", rdy0); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; bit e; int lat;
    run_txn(1'b0, 32'h13, 32'd0, 1'b0, rd, e, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL misal_load_latency got=%0d exp=3", lat); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL misal_load_err got=%b exp=1", e); end
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL misal_load_data got=%h exp=0", rd); end
    run_txn(1'b1, 32'h13, 32'h5, 1'b0, rd, e, lat);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL misal_store_err got=%b exp=1", e); end
    run_txn(1'b0, 32'h10, 32'd0, 1'b0, rd, e, lat);
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL misal_no_write got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; bit e; int lat;
    run_txn(1'b1, 32'h0, 32'h77, 1'b0, rd, e, lat);
    run_txn(1'b1, 32'h100, 32'h99, 1'b0, rd, e, lat);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_store_err got=%b exp=1", e); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL oor_store_dout got=%h exp=deadbeef", rd); end
    run_txn(1'b0, 32'h0, 32'd0, 1'b0, rd, e, lat);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL oor_alias_err got=%b exp=0", e); end
    checks++; if (rd !== 32'h77) begin failures++; $display("FAIL oor_alias_data got=%h exp=00000077", rd); end
  endtask

  task automatic test_toggle_wait();
    logic [31:0] rd; bit e; int lat;
    run_txn(1'b1, 32'h30, 32'hCAFE_F00D, 1'b1, rd, e, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL toggle_store_latency got=%0d exp=3", lat); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL toggle_store_err got=%b exp=0", e); end
    run_txn(1'b0, 32'h30, 32'd0, 1'b1, rd, e, lat);
    checks++; if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL toggle_load_data got=%h exp=cafef00d", rd); end
    run_txn(1'b0, 32'h10, 32'd0, 1'b0, rd, e, lat);
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL toggle_untouched got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; bit e; int lat; int pulses = 0;
    run_txn(1'b1, 32'h20, 32'h1111_2222, 1'b0, rd, e, lat);
    run_txn(1'b0, 32'h10, 32'd0, 1'b0, rd, e, lat);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    req = 1'b0;
    $display("async reset mid-wait ready=%b dout=%h", rdy, dout);
    checks++; if (dout !== 32'd0) begin failures++; $display("FAIL async_reset_dout got=%h exp=0", dout); end
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL async_reset_ready got=%b exp=0", rdy); end
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rdy) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL aborted_ready_pulses got=%0d exp=0", pulses); end
    run_txn(1'b0, 32'h20, 32'd0, 1'b0, rd, e, lat);
    checks++; if (rd !== 32'h1111_2222) begin failures++; $display("FAIL aborted_no_write got=%h exp=11112222", rd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_misaligned();
    test_out_of_range();
    test_toggle_wait();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
